// File: rtl/mips_pkg.sv
// Shared MIPS definitions: FSM state encodings, opcodes, ALU operation codes
// and the packed control word produced by the multicycle controller.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [1:0] ADD   = 2'b00;
    localparam logic [1:0] SUB   = 2'b01;
    localparam logic [1:0] FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // pcwrite and branch stay internal; the top folds them into pcen.
    typedef struct packed {
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder for the multicycle controller.
// Any state without an entry, including unused encodings, yields all zeros.
module mips_ctrl_outdec #(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0]          state,
    output logic [mips_pkg::CTRL_W-1:0] ctrl_word
);
    import mips_pkg::*;

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state)
            STATE_W'(S_FETCH): begin
                c.irwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ADD;
                c.pcsrc   = PCSRC_ALU;
                c.pcwrite = 1'b1;
            end
            STATE_W'(S_DECODE): begin
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ADD;
            end
            STATE_W'(S_MEMADR), STATE_W'(S_ADDIEX): begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ADD;
            end
            STATE_W'(S_MEMRD): c.iord = 1'b1;
            STATE_W'(S_MEMWB): begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            STATE_W'(S_RTYPEEX): begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = FUNCT;
            end
            STATE_W'(S_RTYPEWB): begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            STATE_W'(S_BEQEX): begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
            end
            STATE_W'(S_ADDIWB): c.regwrite = 1'b1;
            STATE_W'(S_JEX): begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        ctrl_word = c;
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing lw/sw/R-type/beq/addi/j,
// with pcen the only output that also depends on the ALU zero flag.
module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [STATE_W-1:0] state
);
    import mips_pkg::*;

    logic [STATE_W-1:0]  state_q;
    logic [STATE_W-1:0]  state_d;
    logic [CTRL_W-1:0]   ctrl_word;
    ctrl_t               ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= STATE_W'(S_FETCH);
        else       state_q <= state_d;
    end

    // op is only looked at in DECODE and MEMADR; unknown opcodes and unused
    // encodings fall back to FETCH.
    always_comb begin
        state_d = STATE_W'(S_FETCH);
        case (state_q)
            STATE_W'(S_FETCH): state_d = STATE_W'(S_DECODE);
            STATE_W'(S_DECODE): begin
                case (op)
                    LW, SW:  state_d = STATE_W'(S_MEMADR);
                    RTYPE:   state_d = STATE_W'(S_RTYPEEX);
                    BEQ:     state_d = STATE_W'(S_BEQEX);
                    ADDI:    state_d = STATE_W'(S_ADDIEX);
                    J:       state_d = STATE_W'(S_JEX);
                    default: state_d = STATE_W'(S_FETCH);
                endcase
            end
            STATE_W'(S_MEMADR): begin
                if (op == LW)      state_d = STATE_W'(S_MEMRD);
                else if (op == SW) state_d = STATE_W'(S_MEMWR);
                else               state_d = STATE_W'(S_FETCH);
            end
            STATE_W'(S_MEMRD):   state_d = STATE_W'(S_MEMWB);
            STATE_W'(S_RTYPEEX): state_d = STATE_W'(S_RTYPEWB);
            STATE_W'(S_ADDIEX):  state_d = STATE_W'(S_ADDIWB);
            default:             state_d = STATE_W'(S_FETCH);
        endcase
    end

    mips_ctrl_outdec #(.STATE_W(STATE_W)) u_outdec (
        .state     (state_q),
        .ctrl_word (ctrl_word)
    );

    always_comb begin
        ctrl     = ctrl_t'(ctrl_word);
        irwrite  = ctrl.irwrite;
        memwrite = ctrl.memwrite;
        regwrite = ctrl.regwrite;
        iord     = ctrl.iord;
        regdst   = ctrl.regdst;
        memtoreg = ctrl.memtoreg;
        alusrca  = ctrl.alusrca;
        alusrcb  = ctrl.alusrcb;
        aluop    = ctrl.aluop;
        pcsrc    = ctrl.pcsrc;
        pcen     = ctrl.pcwrite | (ctrl.branch & zero);
        state    = state_q;
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: a per-cycle vector table checked through an
// expected-value queue, then instruction latency and write-pulse sequences.
module tb_mips_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] act_word;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        state_t     st;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .irwrite  (irwrite),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .iord     (iord),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .pcsrc    (pcsrc),
        .pcen     (pcen),
        .state    (state)
    );

    assign act_word = {state, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
                       alusrca, alusrcb, aluop, pcsrc, pcen};

    // {irwrite,memwrite,regwrite,iord,regdst,memtoreg,alusrca}_alusrcb_aluop_pcsrc_pcen
    function automatic logic [13:0] exp_ctrl(input state_t s, input logic z);
        case (s)
            S_FETCH:   return 14'b1000000_01_00_00_1;
            S_DECODE:  return 14'b0000000_11_00_00_0;
            S_MEMADR:  return 14'b0000001_10_00_00_0;
            S_MEMRD:   return 14'b0001000_00_00_00_0;
            S_MEMWB:   return 14'b0010010_00_00_00_0;
            S_MEMWR:   return 14'b0101000_00_00_00_0;
            S_RTYPEEX: return 14'b0000001_00_10_00_0;
            S_RTYPEWB: return 14'b0010100_00_00_00_0;
            S_BEQEX:   return {13'b0000001_00_01_01, z};
            S_ADDIEX:  return 14'b0000001_10_00_00_0;
            S_ADDIWB:  return 14'b0010000_00_00_00_0;
            S_JEX:     return 14'b0000000_00_00_10_1;
            default:   return 14'b0;
        endcase
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input state_t s, input logic z);
        vec_t v;
        v.rst  = r;
        v.op   = o;
        v.zero = z;
        v.st   = s;
        vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_head(input int idx);
        logic [17:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL vec%0d: expected queue empty, got %b", idx, act_word);
        end else begin
            e = exp_q.pop_front();
            if (act_word !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         idx, act_word[17:14], act_word[13:0], e[17:14], e[13:0]);
            end
        end
    endtask

    // Runs one instruction from FETCH until FETCH recurs; counts cycles and write pulses.
    task automatic run_instr(input string name, input logic [5:0] o,
                             input int exp_cyc, input int exp_mw, input int exp_rw);
        int cyc = 0;
        int mw  = 0;
        int rw  = 0;
        op   = o;
        zero = 1'b0;
        do begin
            #1;
            if (memwrite) mw++;
            if (regwrite) rw++;
            cyc++;
            @(negedge clk);
        end while (state != 4'(S_FETCH) && cyc < 16);
        check_int({name, "_cycles"}, cyc, exp_cyc);
        check_int({name, "_memwrite"}, mw, exp_mw);
        check_int({name, "_regwrite"}, rw, exp_rw);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'd0;
        zero  = 1'b0;

        // reset held
        add(1, rnd_op(), S_FETCH, rz());
        add(1, rnd_op(), S_FETCH, rz());
        // lw, with op changing in states that must ignore it
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, LW,       S_DECODE, rz());
        add(0, LW,       S_MEMADR, rz());
        add(0, RTYPE,    S_MEMRD,  rz());
        add(0, J,        S_MEMWB,  rz());
        // R-type
        add(0, rnd_op(), S_FETCH,   rz());
        add(0, RTYPE,    S_DECODE,  rz());
        add(0, rnd_op(), S_RTYPEEX, rz());
        add(0, rnd_op(), S_RTYPEWB, rz());
        // beq taken then not taken
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, BEQ,      S_DECODE, rz());
        add(0, rnd_op(), S_BEQEX,  1'b1);
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, BEQ,      S_DECODE, rz());
        add(0, rnd_op(), S_BEQEX,  1'b0);
        // illegal opcode
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, 6'h3F,    S_DECODE, rz());
        // reset in MEMRD, held two more cycles, then addi
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, LW,       S_DECODE, rz());
        add(0, LW,       S_MEMADR, rz());
        add(1, rnd_op(), S_MEMRD,  rz());
        add(1, SW,       S_FETCH,  rz());
        add(1, rnd_op(), S_FETCH,  rz());
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, ADDI,     S_DECODE, rz());
        add(0, rnd_op(), S_ADDIEX, rz());
        add(0, rnd_op(), S_ADDIWB, rz());
        // sw, addi, j back to back
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, SW,       S_DECODE, rz());
        add(0, SW,       S_MEMADR, rz());
        add(0, rnd_op(), S_MEMWR,  rz());
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, ADDI,     S_DECODE, rz());
        add(0, rnd_op(), S_ADDIEX, rz());
        add(0, rnd_op(), S_ADDIWB, rz());
        add(0, rnd_op(), S_FETCH,  rz());
        add(0, J,        S_DECODE, rz());
        add(0, rnd_op(), S_JEX,    rz());
        add(0, rnd_op(), S_FETCH,  rz());

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            op    = vecs[i].op;
            zero  = vecs[i].zero;
            exp_q.push_back({4'(vecs[i].st), exp_ctrl(vecs[i].st, vecs[i].zero)});
            #1;
            check_head(i);
        end

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        run_instr("lw",      LW,    5, 0, 1);
        run_instr("sw",      SW,    4, 1, 0);
        run_instr("addi",    ADDI,  4, 0, 1);
        run_instr("j",       J,     3, 0, 0);
        run_instr("rtype",   RTYPE, 4, 0, 1);
        run_instr("beq",     BEQ,   3, 0, 0);
        run_instr("illegal", 6'h3F, 2, 0, 0);

        check_int("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have parameter STATE_W, default 4, meaning the state register width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port op, input, 6, the instruction opcode field from the instruction register.
REQ-005 SHALL have port zero, input, 1, the ALU zero flag.
REQ-006 SHALL have ports irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca, output, 1 each, the datapath enables and mux selects.
REQ-007 SHALL have port alusrcb, output, 2: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-008 SHALL have port aluop, output, 2: 00 add, 01 subtract, 10 decode funct. This port drives the ALU control block's aluop input.
REQ-009 SHALL have port pcsrc, output, 2: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 SHALL have port pcen, output, 1, the PC write enable.

Function
REQ-011 SHALL implement a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-012 SHALL use these transitions, each taking one cycle:
  - FETCH->DECODE.
  - DECODE->MEMADR for op 100011 (lw) or 101011 (sw); RTYPEEX for 000000; BEQEX for 000100; ADDIEX for 001000; JEX for 000010.
  - MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX all ->FETCH.
REQ-013 SHALL send DECODE->FETCH on any other opcode, with no register or memory write.
REQ-014 SHALL drive these outputs in FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-015 SHALL drive these outputs in DECODE: alusrca=0, alusrcb=11, aluop=00.
REQ-016 SHALL drive these outputs in MEMADR: alusrca=1, alusrcb=10, aluop=00.
REQ-017 SHALL drive iord=1 in MEMRD.
REQ-018 SHALL drive regdst=0, memtoreg=1, regwrite=1 in MEMWB.
REQ-019 SHALL drive iord=1, memwrite=1 in MEMWR.
REQ-020 SHALL drive alusrca=1, alusrcb=00, aluop=10 in RTYPEEX.
REQ-021 SHALL drive regdst=1, memtoreg=0, regwrite=1 in RTYPEWB.
REQ-022 SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 in BEQEX.
REQ-023 SHALL drive alusrca=1, alusrcb=10, aluop=00 in ADDIEX.
REQ-024 SHALL drive regdst=0, memtoreg=0, regwrite=1 in ADDIWB.
REQ-025 SHALL drive pcsrc=10, pcwrite=1 in JEX.
REQ-026 SHALL hold every output not listed for a state at 0.
REQ-027 SHALL compute pcen = pcwrite | (branch & zero) combinationally; pcwrite and branch are internal.
REQ-028 SHALL keep all other outputs purely state-decoded (Moore), with no dependence on zero or op within a state.
REQ-029 SHALL sample op only in DECODE and MEMADR; changes to op in other states SHALL have no effect.
REQ-030 SHALL give instruction latency by class: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-031 SHALL decode unused state encodings to FETCH on the next edge, with all outputs 0 while in them.

Reset
REQ-032 SHALL load FETCH on the first rising clk edge with reset=1, regardless of the current state, including mid-instruction.
REQ-033 SHALL keep the FSM in FETCH while reset is held; outputs SHALL be the FETCH values of REQ-014, so pcen=1.
REQ-034 SHALL leave FETCH on the first edge after reset deasserts; there is no asynchronous path.

Structure
REQ-035 SHALL place the state encodings, opcode constants (LW, SW, RTYPE, BEQ, ADDI, J) and aluop codes (ADD=00, SUB=01, FUNCT=10) in the shared MIPS package used by the ALU control block.
REQ-036 SHALL split out one sub-module, mips_ctrl_outdec, a combinational state-to-control-word decoder; the state register and next-state logic remain in the top module.

Verification
REQ-037 SHALL cover lw: reset, then op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 only in cycle 5; memtoreg=1 in cycle 5.
REQ-038 SHALL cover R-type: op=000000 -> aluop=10 only in cycle 3; regdst=1, regwrite=1 in cycle 4; back in FETCH in cycle 5.
REQ-039 SHALL cover beq: op=000100 with zero=1 in BEQEX -> pcen=1, pcsrc=01, aluop=01; repeated with zero=0 -> pcen=0.
REQ-040 SHALL cover illegal opcode: op=111111 -> DECODE then FETCH, with regwrite, memwrite and pcen all 0 in DECODE.
REQ-041 SHALL cover reset mid-operation: reset=1 asserted in MEMRD -> FETCH next edge, memwrite=0 and regwrite=0 throughout, FETCH outputs while reset is held.
REQ-042 SHALL cover back-to-back instructions: sw, addi, j -> cycle counts 4, 4, 3; memwrite pulses exactly once; pcsrc=10 in JEX.
